// File: rtl/posit_add_arbiter.sv
// Round-robin arbiter that shares one pipelined, in-order posit adder between
// NREQ requesters and routes results back by tag. Optional counters: POSIT_ADD_ARBITER_STATS_EN.
module posit_add_arbiter #(
  parameter int N     = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  output logic              add_start,
  input  logic [N-1:0]      add_result,
  input  logic              add_inf,
  input  logic              add_zero,
  input  logic              add_done,
  output logic [NREQ-1:0]   res_valid,
  output logic [N-1:0]      res_data,
  output logic              res_inf,
  output logic              res_zero,
  output logic              busy,
  output logic              err_underflow
`ifdef POSIT_ADD_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [TW-1:0]   cand;

  logic [TW-1:0]   tag_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            blocked;

  // Stage p0: combinational round-robin search starting just after the last winner
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = TW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

  assign pop       = add_done && (count != '0);
  assign fifo_full = (count == CW'(DEPTH));
  // A full FIFO still accepts an issue in the cycle it retires the head tag.
  assign blocked   = fifo_full && !pop;
  assign req_ready = (!aresetn || blocked) ? '0 : grant;
  assign push      = |(req_valid & req_ready);
  assign busy      = (count != '0) | add_start;

  // Stage p1: issue registers, tag FIFO control and result return
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr        <= TW'(NREQ - 1);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      add_start     <= 1'b0;
      add_in1       <= '0;
      add_in2       <= '0;
      res_valid     <= '0;
      res_data      <= '0;
      res_inf       <= 1'b0;
      res_zero      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      add_start <= push;
      if (push) begin
        add_in1 <= req_in1[grant_idx*N +: N];
        add_in2 <= req_in2[grant_idx*N +: N];
        rr_ptr  <= grant_idx;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        res_data <= add_result;
        res_inf  <= add_inf;
        res_zero <= add_zero;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      res_valid <= pop ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
      if (add_done && (count == '0)) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

`ifdef POSIT_ADD_ARBITER_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (push) stat_issued <= stat_issued + 32'd1;
      if (|req_valid && !push) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: a queue-based reference model checked every cycle,
// a configurable-latency stand-in adder, and directed scenarios with literal expectations.
module tb_posit_add_arbiter;

  localparam int N     = 32;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] NAR = 32'h8000_0000;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic [N-1:0]      add_in1, add_in2;
  logic              add_start;
  logic [N-1:0]      add_result;
  logic              add_inf, add_zero, add_done;
  logic [NREQ-1:0]   res_valid;
  logic [N-1:0]      res_data;
  logic              res_inf, res_zero, busy, err_underflow;

  posit_add_arbiter #(.N(N), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .res_valid(res_valid), .res_data(res_data), .res_inf(res_inf), .res_zero(res_zero),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in adder: exact for 1.0+1.0=2.0 and NaR propagation, integer sum otherwise.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return a + b;
  endfunction

  int          lat = 3;
  logic        force_done = 1'b0;
  logic [7:0]  sv;
  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        dv;
  logic [31:0] da, db;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sv <= '0;
      for (int k = 0; k < 8; k++) begin sa[k] <= '0; sb[k] <= '0; end
    end else begin
      sv    <= {sv[6:0], add_start};
      sa[0] <= add_in1;
      sb[0] <= add_in2;
      for (int k = 1; k < 8; k++) begin sa[k] <= sa[k-1]; sb[k] <= sb[k-1]; end
    end
  end

  always_comb begin
    dv = add_start; da = add_in1; db = add_in2;
    if (lat > 0) begin dv = sv[lat-1]; da = sa[lat-1]; db = sb[lat-1]; end
  end
  assign add_done   = dv | force_done;
  assign add_result = fadd(da, db);
  assign add_inf    = (add_result == NAR);
  assign add_zero   = (add_result == 32'h0);

  // Reference model: expected register outputs for the current cycle
  int          tagq [$];
  int          m_rr = NREQ - 1;
  logic        m_start = 0;
  logic [31:0] m_in1 = 0, m_in2 = 0, m_data = 0;
  logic [3:0]  m_rv = 0;
  logic        m_inf = 0, m_zero = 0, m_err = 0;

  int          res_log [$];
  logic        res_inf_log [$];
  logic        res_zero_log [$];

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_start", 32'(add_start), 0);
      chk("rst_in1", add_in1, 0);
      chk("rst_resv", 32'(res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_underflow), 0);
      tagq.delete();
      m_rr = NREQ - 1; m_start = 0; m_in1 = 0; m_in2 = 0; m_data = 0;
      m_rv = 0; m_inf = 0; m_zero = 0; m_err = 0;
    end else begin
      bit       pop, blocked;
      int       g;
      logic [3:0] exp_ready;
      pop     = add_done && (tagq.size() > 0);
      blocked = (tagq.size() == DEPTH) && !pop;
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_ready = (blocked || g < 0) ? 4'b0 : 4'(1 << g);

      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("add_start", 32'(add_start), 32'(m_start));
      chk("add_in1", add_in1, m_in1);
      chk("add_in2", add_in2, m_in2);
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("res_data", res_data, m_data);
      chk("res_inf", 32'(res_inf), 32'(m_inf));
      chk("res_zero", 32'(res_zero), 32'(m_zero));
      chk("busy", 32'(busy), 32'((tagq.size() != 0) || m_start));
      chk("err_underflow", 32'(err_underflow), 32'(m_err));

      for (int i = 0; i < NREQ; i++)
        if (res_valid[i]) begin
          res_log.push_back(i);
          res_inf_log.push_back(res_inf);
          res_zero_log.push_back(res_zero);
        end

      if (add_done && tagq.size() == 0) m_err = 1;
      if (pop) begin
        m_rv   = 4'(1 << tagq.pop_front());
        m_data = add_result;
        m_inf  = add_inf;
        m_zero = add_zero;
      end else begin
        m_rv = 0;
      end
      if (exp_ready != 0) begin
        tagq.push_back(g);
        m_start = 1;
        m_in1   = req_in1[g*N +: N];
        m_in2   = req_in2[g*N +: N];
        m_rr    = g;
      end else begin
        m_start = 0;
      end
    end
  end

  // Directed stimulus
  logic [31:0] op1 [NREQ][16];
  logic [31:0] op2 [NREQ][16];
  int          hs_log [$];
  int          hs_cyc [$];

  task automatic fill_ops();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 16; k++) begin
        op1[i][k] = 32'h1000_0000 * (i + 1) + k;
        op2[i][k] = 32'h0000_0100 * (k + 1) + i;
      end
  endtask

  task automatic clear_logs();
    hs_log.delete(); hs_cyc.delete();
    res_log.delete(); res_inf_log.delete(); res_zero_log.delete();
  endtask

  task automatic run_ops(input logic [3:0] mask, input int nops, input int budget);
    int rem [NREQ];
    int idx [NREQ];
    logic [3:0] hs;
    int n;
    bit pending;
    for (int i = 0; i < NREQ; i++) begin rem[i] = mask[i] ? nops : 0; idx[i] = 0; end
    n = 0;
    pending = 1;
    while (pending && n < budget) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (rem[i] > 0);
        req_in1[i*N +: N] = op1[i][idx[i] % 16];
        req_in2[i*N +: N] = op2[i][idx[i] % 16];
      end
      @(negedge aclk);
      hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++)
        if (hs[i]) begin hs_log.push_back(i); hs_cyc.push_back(cyc); end
      @(posedge aclk); #1;
      pending = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin idx[i]++; rem[i]--; end
        if (rem[i] > 0) pending = 1;
      end
      n++;
    end
    chk("issue_budget", 32'(pending), 0);
    req_valid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || sv != 0) && n < 200) begin @(negedge aclk); n++; end
    chk("drain_budget", 32'(n >= 200), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge aclk); #2;
    aresetn = 1'b0;
    req_valid = '0;
    @(negedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_in1 = '0; req_in2 = '0;
    fill_ops();
    repeat (2) @(negedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single op, 1.0 + 1.0 with a 3-cycle adder
    lat = 3;
    req_valid = 4'b0001;
    req_in1[0 +: N] = 32'h4000_0000;
    req_in2[0 +: N] = 32'h4000_0000;
    @(negedge aclk);
    chk("single_ready_t", 32'(req_ready), 32'h1);
    @(posedge aclk); #1;
    req_valid = '0;
    @(negedge aclk);
    chk("single_start_t1", 32'(add_start), 32'h1);
    chk("single_in1_t1", add_in1, 32'h4000_0000);
    repeat (3) begin
      @(negedge aclk);
      chk("single_no_res_early", 32'(res_valid), 32'h0);
    end
    @(negedge aclk);
    chk("single_resv_t5", 32'(res_valid), 32'h1);
    chk("single_data_t5", res_data, 32'h4800_0000);
    @(posedge aclk); #1;
    drain();

    // Round robin, all four requesters continuously valid
    do_reset();
    fill_ops(); clear_logs();
    lat = 3;
    run_ops(4'b1111, 3, 40);
    drain();
    chk("rr_count", 32'(hs_log.size()), 12);
    for (int i = 0; i < hs_log.size() && i < 12; i++) begin
      chk("rr_order", 32'(hs_log[i]), 32'(i % 4));
      if (i > 0) chk("rr_back_to_back", 32'(hs_cyc[i] - hs_cyc[i-1]), 1);
    end
    chk("rr_res_count", 32'(res_log.size()), 12);
    for (int i = 0; i < res_log.size() && i < 12; i++)
      chk("rr_res_order", 32'(res_log[i]), 32'(i % 4));

    // Full stall: FIFO depth 4, adder latency 8, requester 2 only
    do_reset();
    fill_ops(); clear_logs();
    lat = 8;
    run_ops(4'b0100, 8, 60);
    drain();
    chk("stall_count", 32'(hs_log.size()), 8);
    if (hs_cyc.size() == 8) begin
      int gaps [7] = '{1, 1, 1, 6, 1, 1, 1};
      for (int i = 1; i < 8; i++)
        chk("stall_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(gaps[i-1]));
    end
    chk("stall_res_count", 32'(res_log.size()), 8);
    for (int i = 0; i < res_log.size(); i++)
      chk("stall_res_tag", 32'(res_log[i]), 2);

    // Zero-latency adder, requesters 1 and 3, NaR and zero flags
    do_reset();
    fill_ops(); clear_logs();
    op1[1][0] = NAR;
    op1[3][0] = 32'h0; op2[3][0] = 32'h0;
    lat = 0;
    run_ops(4'b1010, 3, 20);
    drain();
    chk("zl_count", 32'(hs_log.size()), 6);
    for (int i = 0; i < hs_log.size() && i < 6; i++)
      chk("zl_order", 32'(hs_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    chk("zl_res_count", 32'(res_log.size()), 6);
    for (int i = 0; i < res_log.size() && i < 6; i++)
      chk("zl_res_order", 32'(res_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    if (res_inf_log.size() >= 3) begin
      chk("zl_nar_inf", 32'(res_inf_log[0]), 1);
      chk("zl_zero_flag", 32'(res_zero_log[1]), 1);
      chk("zl_plain_inf", 32'(res_inf_log[2]), 0);
    end

    // Underflow: done pulse with nothing outstanding
    do_reset();
    lat = 3;
    force_done = 1'b1;
    @(posedge aclk); #1;
    force_done = 1'b0;
    @(negedge aclk);
    chk("uf_err_set", 32'(err_underflow), 1);
    chk("uf_no_res", 32'(res_valid), 0);
    repeat (3) @(negedge aclk);
    chk("uf_err_sticky", 32'(err_underflow), 1);
    @(posedge aclk); #1;

    // Reset with three ops outstanding
    do_reset();
    fill_ops(); clear_logs();
    lat = 8;
    run_ops(4'b0111, 1, 20);
    chk("mid_outstanding", 32'(busy), 1);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_start", 32'(add_start), 0);
    chk("mid_rst_in1", add_in1, 0);
    chk("mid_rst_in2", add_in2, 0);
    chk("mid_rst_resv", 32'(res_valid), 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err_underflow), 0);
    @(negedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    clear_logs();
    run_ops(4'b1111, 1, 20);
    drain();
    chk("mid_first_winner", (hs_log.size() > 0) ? 32'(hs_log[0]) : 32'hFFFF_FFFF, 0);
    chk("mid_res_count", 32'(res_log.size()), 4);
    chk("mid_no_underflow", 32'(err_underflow), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/posit_add_arbiter.md
Name: posit_add_arbiter

Overview:
- Shares one pipelined posit adder between NREQ requesters, e.g. the pairHMM PE lanes.
- Arbitrates with a round-robin scheme, registers the winning operands and pulses the adder start.
- Tracks the issuing requester of each in-flight op in an in-order tag FIFO.
- Routes each adder result (result/inf/zero) back to its requester as a one-cycle valid pulse.

Parameters:
- N, 32, posit width.
- NREQ, 4, number of requesters (2..16).
- DEPTH, 8, maximum outstanding ops (tag FIFO depth, power of 2, ≥ adder latency + 1 for full throughput).
- TW, max(1,clog2(NREQ)), tag width (derived, localparam).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_in1  in  NREQ*N  packed operand 1, requester i at [i*N +: N]
- req_in2  in  NREQ*N  packed operand 2
- add_in1  out  N  to adder in1
- add_in2  out  N  to adder in2
- add_start  out  1  to adder start
- add_result  in  N  from adder result
- add_inf  in  1  from adder inf
- add_zero  in  1  from adder zero
- add_done  in  1  from adder done
- res_valid  out  NREQ  one-cycle result pulse per requester
- res_data  out  N  result (shared bus, qualified by res_valid)
- res_inf  out  1  inf flag
- res_zero  out  1  zero flag
- busy  out  1  FIFO not empty, or add_start high
- err_underflow  out  1  sticky: add_done with no outstanding tag

Behaviour:
- Reset (async, aresetn low) clears all of the following at once:
  - outputs: req_ready, add_start, add_in1/2, res_valid, res_data, res_inf, res_zero, busy, err_underflow all 0;
  - tag FIFO emptied;
  - rr_ptr = NREQ-1, so requester 0 has priority first.
- Arbitration (combinational):
  - Candidate set is req_valid.
  - Search starts at rr_ptr+1 modulo NREQ; the first set bit wins → grant one-hot.
  - Arbiter is blocked when fifo_full && !pop.
  - req_ready = blocked ? 0 : grant.
  - A handshake is req_valid[i] & req_ready[i]; at most one per cycle.
- Issue (registered). On a handshake at cycle t:
  - add_in1/add_in2 ← that requester's operands;
  - add_start = 1 at t+1;
  - tag i pushed into the FIFO at the t edge;
  - rr_ptr ← i.
- With no handshake:
  - add_start = 0;
  - add_in1/2 hold their last value.
- Back-to-back issue is allowed every cycle; throughput is 1 op/cycle.
- Return. On add_done at cycle d:
  - pop the head tag h;
  - at d+1: res_valid = one-hot(h), res_data = add_result, res_inf = add_inf, res_zero = add_zero, all sampled at d;
  - otherwise res_valid = 0; res_data and flags hold.
- The adder is treated as fixed-latency and in-order (latency L ≥ 0 from add_start to add_done; L = 0, done = start, is legal). No reordering is supported.
- FIFO: count range 0..DEPTH; full = (count == DEPTH).
  - Push on a full FIFO happens only when a pop occurs in the same cycle; count is unchanged in that case.
  - Simultaneous push and pop on an empty FIFO is illegal; when L = 0 the pop refers to a tag pushed in an earlier cycle.
- Underflow: add_done with count == 0 → no pop, no res_valid, err_underflow ← 1 (sticky until reset).
- Requester rules:
  - Operands must stay stable while valid && !ready.
  - Deasserting valid without a handshake is permitted; the arbiter never latches requests.
- busy = (count != 0) | add_start.
- A reset mid-operation discards all in-flight tags. Adder results arriving after reset deassertion set err_underflow; the bench must reset the adder together with this block.

Optional Feature:
- Macro: POSIT_ADD_ARBITER_STATS_EN.
- When defined, adds outputs stat_issued (32 bits, handshake count) and stat_stall (32 bits, cycles where |req_valid && no handshake).
- Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single op: req_valid[0]=1, in1=in2=0x40000000 (1.0), model adder L=3 returns 0x48000000.
  - Required: req_ready[0] high the same cycle, add_start at t+1, res_valid=4'b0001 with res_data=0x48000000 at t+5.
- Round robin: all four valid continuously.
  - Required: grants 0,1,2,3,0,1… one per cycle; results return in the same order tagged correctly.
- Full stall: DEPTH=4, L=8, requester 2 always valid.
  - Required: 4 issues, then req_ready=0 until the first add_done, then resume 1/cycle; no tag lost.
- Zero-latency adder (L=0, done=start): alternating requesters 1 and 3.
  - Required: res_valid one-hot matches the issuing order; inf/zero flags pass through, e.g. operand 0x80000000 → res_inf=1.
- Underflow: pulse add_done with FIFO empty.
  - Required: err_underflow=1 and stays high; no res_valid.
- Reset mid-flight: aresetn low with 3 outstanding.
  - Required: all outputs 0 immediately; after release, requester 0 wins first.
